// File: rtl/conv_stream_engine.sv
// Streaming KSIZE x KSIZE convolution engine: multiply, adder tree, channel accumulate, round/shift/saturate.
// Latency: a last-channel beat accepted on edge E shows out_valid after edge E+2; each stalled cycle adds one.
// Backpressure: en = !out_valid | out_ready freezes the whole pipe and drops win_ready while a pixel waits.
// Optional ReLU clamp on the quantised output is built when CONV_RELU_EN is defined.
module conv_stream_engine #(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 4,
  parameter int BIAS_WIDTH   = 8,
  parameter int KSIZE        = 5,
  parameter int ACC_WIDTH    = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [7:0]                           cfg_num_ch,
  input  logic [15:0]                          cfg_num_out,
  input  logic [4:0]                           cfg_shift,
  input  logic                                 win_valid,
  output logic                                 win_ready,
  input  logic [KSIZE*KSIZE*DATA_WIDTH-1:0]    win_data,
  input  logic [KSIZE*KSIZE*WEIGHT_WIDTH-1:0]  wgt_data,
  input  logic [BIAS_WIDTH-1:0]                bias,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DATA_WIDTH-1:0]                out_data,
  output logic                                 busy,
  output logic                                 done
);

  localparam int NE = KSIZE * KSIZE;
  localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = (ACC_WIDTH'(1) << (DATA_WIDTH - 1)) - ACC_WIDTH'(1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  num_ch_q, num_ch_d;
  logic [4:0]  shift_q, shift_d;
  logic [15:0] pix_rem_q, pix_rem_d;   // pixels whose beats are still to be accepted
  logic [15:0] out_rem_q, out_rem_d;   // pixels still to be handed to the consumer
  logic [7:0]  ch_cnt_q, ch_cnt_d;

  logic en, last_ch, accept, out_hs;

  // Stage 1: products and bias
  logic                   s1_vld_q, s1_last_q;
  logic signed [PW-1:0]   prod_d [NE];
  logic signed [PW-1:0]   prod_q [NE];
  logic [BIAS_WIDTH-1:0]  s1_bias_q;

  // Stage 2: tree sum
  logic                         s2_vld_q, s2_last_q;
  logic signed [ACC_WIDTH-1:0]  sum_d, sum_q;
  logic [BIAS_WIDTH-1:0]        s2_bias_q;

  // Stage 3: accumulate / quantise
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0]  bias_ext, rnd, v, q;
  logic                         out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0]        out_dat_q, out_dat_d;

  assign en        = !out_vld_q | out_ready;
  assign last_ch   = (ch_cnt_q == num_ch_q - 8'd1);
  assign win_ready = (state_q == ST_RUN) & en & (pix_rem_q != 16'd0);
  assign accept    = win_valid & win_ready;
  assign out_hs    = out_vld_q & out_ready;

  assign out_valid = out_vld_q;
  assign out_data  = out_dat_q;
  assign busy      = (state_q == ST_RUN) | (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);

  // Job sequencing: config latch, beat/pixel counters and next state
  always_comb begin
    state_d   = state_q;
    num_ch_d  = num_ch_q;
    shift_d   = shift_q;
    pix_rem_d = pix_rem_q;
    out_rem_d = out_rem_q;
    ch_cnt_d  = ch_cnt_q;
    if (out_hs && out_rem_q != 16'd0) begin
      out_rem_d = out_rem_q - 16'd1;
    end
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_ch_d  = (cfg_num_ch == 8'd0) ? 8'd1 : cfg_num_ch;
          shift_d   = cfg_shift;
          pix_rem_d = cfg_num_out;
          out_rem_d = cfg_num_out;
          ch_cnt_d  = 8'd0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (pix_rem_q == 16'd0) begin
          // only reachable for an empty job
          state_d = ST_DONE;
        end else if (accept) begin
          if (last_ch) begin
            ch_cnt_d  = 8'd0;
            pix_rem_d = pix_rem_q - 16'd1;
            if (pix_rem_q == 16'd1) begin
              state_d = ST_DRAIN;
            end
          end else begin
            ch_cnt_d = ch_cnt_q + 8'd1;
          end
        end
      end
      ST_DRAIN: begin
        if (out_hs && out_rem_q == 16'd1) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      num_ch_q  <= 8'd1;
      shift_q   <= 5'd0;
      pix_rem_q <= 16'd0;
      out_rem_q <= 16'd0;
      ch_cnt_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      num_ch_q  <= num_ch_d;
      shift_q   <= shift_d;
      pix_rem_q <= pix_rem_d;
      out_rem_q <= out_rem_d;
      ch_cnt_q  <= ch_cnt_d;
    end
  end

  // Element-wise signed products, both operands widened to the product width
  always_comb begin
    for (int i = 0; i < NE; i++) begin
      prod_d[i] = $signed({{WEIGHT_WIDTH{win_data[i*DATA_WIDTH+DATA_WIDTH-1]}},
                           win_data[i*DATA_WIDTH +: DATA_WIDTH]})
                * $signed({{DATA_WIDTH{wgt_data[i*WEIGHT_WIDTH+WEIGHT_WIDTH-1]}},
                           wgt_data[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]});
    end
  end

  // Stage 1 register: products, last tag, bias captured on the last-channel beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s1_bias_q <= '0;
      for (int i = 0; i < NE; i++) begin
        prod_q[i] <= '0;
      end
    end else if (en) begin
      s1_vld_q  <= accept;
      s1_last_q <= last_ch;
      if (accept) begin
        prod_q <= prod_d;
      end
      if (accept && last_ch) begin
        s1_bias_q <= bias;
      end
    end
  end

  // Adder tree over the registered products, sign-extended to the accumulator width
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NE; i++) begin
      sum_d = sum_d + {{(ACC_WIDTH-PW){prod_q[i][PW-1]}}, prod_q[i]};
    end
  end

  // Stage 2 register: window sum and the bias travelling with its pixel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_vld_q  <= 1'b0;
      s2_last_q <= 1'b0;
      sum_q     <= '0;
      s2_bias_q <= '0;
    end else if (en) begin
      s2_vld_q  <= s1_vld_q;
      s2_last_q <= s1_last_q;
      if (s1_vld_q) begin
        sum_q <= sum_d;
      end
      if (s1_vld_q && s1_last_q) begin
        s2_bias_q <= s1_bias_q;
      end
    end
  end

  // Accumulate, then on the last channel: add scaled bias and rounding, shift, saturate
  always_comb begin
    bias_ext  = {{(ACC_WIDTH-BIAS_WIDTH){s2_bias_q[BIAS_WIDTH-1]}}, s2_bias_q};
    rnd       = (shift_q != 5'd0) ? (ACC_WIDTH'(1) << (shift_q - 5'd1)) : '0;
    v         = acc_q + sum_q + (bias_ext <<< shift_q) + rnd;
    q         = v >>> shift_q;
    acc_d     = acc_q;
    out_dat_d = out_dat_q;
    out_vld_d = s2_vld_q & s2_last_q;
    if (q > SAT_MAX) begin
      out_dat_d = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (q < SAT_MIN) begin
      out_dat_d = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      out_dat_d = q[DATA_WIDTH-1:0];
    end
`ifdef CONV_RELU_EN
    if (out_dat_d[DATA_WIDTH-1]) begin
      out_dat_d = '0;
    end
`endif
    if (s2_vld_q) begin
      acc_d = s2_last_q ? '0 : (acc_q + sum_q);
    end
    if (!(s2_vld_q && s2_last_q)) begin
      out_dat_d = out_dat_q;
    end
  end

  // Stage 3 register: accumulator and output pixel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
    end else if (en) begin
      acc_q     <= acc_d;
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
    end
  end

endmodule

// File: tb/tb_conv_stream_engine.sv
// Self-checking bench for conv_stream_engine: directed spec cases plus randomized jobs
// checked against a plain-arithmetic reference (dot products, rounding division, clamp).
// Inputs are driven on the falling edge; outputs are sampled 1ns later.
module tb_conv_stream_engine;
  localparam int DW = 8;
  localparam int WW = 4;
  localparam int BW = 8;
  localparam int NE = 25;

  logic              clk = 1'b0;
  logic              rst, start;
  logic [7:0]        cfg_num_ch;
  logic [15:0]       cfg_num_out;
  logic [4:0]        cfg_shift;
  logic              win_valid, win_ready;
  logic [NE*DW-1:0]  win_data;
  logic [NE*WW-1:0]  wgt_data;
  logic [BW-1:0]     bias;
  logic              out_valid, out_ready;
  logic [DW-1:0]     out_data;
  logic              busy, done;

  int total = 0;
  int bad   = 0;

  logic [NE*DW-1:0] bw[$];
  logic [NE*WW-1:0] bk[$];
  logic [BW-1:0]    bb[$];
  int got[$];
  int expq[$];

  int done_cnt, done_cycle, hs_at_done, busy_at_done, stall_seen, stall_bad, extra_valid, busy_after;
  bit noise_start = 1'b0;

  conv_stream_engine dut (
    .clk(clk), .rst(rst), .start(start), .cfg_num_ch(cfg_num_ch), .cfg_num_out(cfg_num_out),
    .cfg_shift(cfg_shift), .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .wgt_data(wgt_data), .bias(bias), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [NE*DW-1:0] fill_win(input int val, input int n);
    logic [NE*DW-1:0] w = '0;
    for (int i = 0; i < n; i++) w[i*DW +: DW] = DW'(val);
    return w;
  endfunction

  function automatic logic [NE*WW-1:0] fill_wgt(input int val, input int n);
    logic [NE*WW-1:0] k = '0;
    for (int i = 0; i < n; i++) k[i*WW +: WW] = WW'(val);
    return k;
  endfunction

  function automatic logic [NE*DW-1:0] rand_win();
    logic [NE*DW-1:0] w;
    for (int i = 0; i < NE; i++) w[i*DW +: DW] = DW'($urandom);
    return w;
  endfunction

  function automatic logic [NE*WW-1:0] rand_wgt();
    logic [NE*WW-1:0] k;
    for (int i = 0; i < NE; i++) k[i*WW +: WW] = WW'($urandom);
    return k;
  endfunction

  function automatic int dot(input logic [NE*DW-1:0] w, input logic [NE*WW-1:0] k);
    int s = 0;
    for (int i = 0; i < NE; i++) s += int'($signed(w[i*DW +: DW])) * int'($signed(k[i*WW +: WW]));
    return s;
  endfunction

  // Reference quantiser: (total + bias*2^sh + half) / 2^sh rounded toward -inf, clamped
  function automatic int quant(input int t, input int b, input int sh);
    int v, q;
    v = t + (b <<< sh);
    if (sh > 0) v += (1 <<< (sh - 1));
    q = v >>> sh;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
`ifdef CONV_RELU_EN
    if (q < 0) q = 0;
`endif
    return q;
  endfunction

  task automatic clear_beats();
    bw.delete(); bk.delete(); bb.delete();
  endtask

  task automatic add_beat(input logic [NE*DW-1:0] w, input logic [NE*WW-1:0] k, input logic [BW-1:0] b);
    bw.push_back(w); bk.push_back(k); bb.push_back(b);
  endtask

  task automatic build_expected(input int nc_raw, input int nout, input int sh);
    int nc, t;
    nc = (nc_raw == 0) ? 1 : nc_raw;
    expq.delete();
    for (int p = 0; p < nout; p++) begin
      t = 0;
      for (int c = 0; c < nc; c++) t += dot(bw[p*nc+c], bk[p*nc+c]);
      expq.push_back(quant(t, int'($signed(bb[p*nc+nc-1])), sh));
    end
  endtask

  // Called on a falling edge in IDLE; returns on the falling edge after the start edge
  task automatic do_start(input int nc, input int nout, input int sh);
    start = 1'b1; cfg_num_ch = 8'(nc); cfg_num_out = 16'(nout); cfg_shift = 5'(sh);
    @(negedge clk);
    start = 1'b0; cfg_num_ch = 8'($urandom); cfg_num_out = 16'($urandom); cfg_shift = 5'($urandom);
  endtask

  // Drives the queued beats, collects handshaked pixels and records protocol observations.
  // ready_mode: 0 random, 1 always ready, 2 ready low on cycles 3..7.
  task automatic run_job(input int ready_mode, input bit all_valid);
    int idx = 0, cyc = 0, hs = 0;
    got.delete();
    done_cnt = 0; done_cycle = -1; hs_at_done = -1; busy_at_done = -1;
    stall_seen = 0; stall_bad = 0; extra_valid = 0; busy_after = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      case (ready_mode)
        1: out_ready = 1'b1;
        2: out_ready = !(cyc >= 3 && cyc <= 7);
        default: out_ready = ($urandom % 3) != 0;
      endcase
      if (idx < bw.size() && (all_valid || ($urandom % 4) != 0)) begin
        win_valid = 1'b1; win_data = bw[idx]; wgt_data = bk[idx]; bias = bb[idx];
      end else begin
        win_valid = 1'b0; win_data = rand_win(); wgt_data = rand_wgt(); bias = BW'($urandom);
      end
      if (noise_start) begin
        start = 1'($urandom); cfg_num_ch = 8'($urandom); cfg_num_out = 16'($urandom); cfg_shift = 5'($urandom);
      end
      #1;
      if (out_valid && !out_ready) begin
        stall_seen++;
        if (win_ready) stall_bad++;
      end
      if (out_valid && out_ready) begin
        got.push_back(int'($signed(out_data)));
        hs++;
      end
      if (win_valid && win_ready) idx++;
      if (done) begin
        done_cnt++; done_cycle = cyc; hs_at_done = hs; busy_at_done = int'(busy);
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; win_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (done) done_cnt++;
      if (out_valid) extra_valid++;
      if (busy) busy_after++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    win_valid = 1'b1; out_ready = 1'b0; #1;
    total++; if (win_ready !== 1'b0) begin bad++; $display("FAIL reset_win_ready got=%b want=0", win_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 8'd0) begin bad++; $display("FAIL reset_out_data got=%0d want=0", out_data); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_busy_done got=%b%b want=00", busy, done); end
    @(negedge clk); rst = 1'b0; @(negedge clk); #1;
    total++; if (win_ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL idle_after_reset got=%b%b want=00", win_ready, busy); end
    win_valid = 1'b0; @(negedge clk);
  endtask

  task automatic test_basic();
    do_start(1, 1, 0); #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", busy); end
    win_data = fill_win(1, NE); wgt_data = fill_wgt(1, NE); bias = '0; win_valid = 1'b1; out_ready = 1'b1; #1;
    total++; if (win_ready !== 1'b1) begin bad++; $display("FAIL basic_win_ready got=%b want=1", win_ready); end
    @(negedge clk); win_valid = 1'b0; win_data = rand_win(); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_lat_e1 got=%b want=0", out_valid); end
    @(negedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_lat_e2 got=%b want=0", out_valid); end
    @(negedge clk); #1;
    total++; if (out_valid !== 1'b1 || out_data !== 8'd25) begin bad++; $display("FAIL basic_out got=%b/%0d want=1/25", out_valid, out_data); end
    @(negedge clk); #1;
    total++; if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL basic_done got=%b%b%b want=100", done, busy, out_valid); end
    @(negedge clk); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_once got=%b want=0", done); end
    @(negedge clk);
  endtask

  task automatic test_saturate();
    clear_beats();
    add_beat(fill_win(2, NE), fill_wgt(1, NE), BW'($urandom));
    add_beat(fill_win(2, NE), fill_wgt(1, NE), BW'($urandom));
    add_beat(fill_win(2, NE), fill_wgt(1, NE), 8'd0);
    do_start(3, 1, 0);
    run_job(1, 1'b1);
    total++; if (got.size() !== 1) begin bad++; $display("FAIL sat_count got=%0d want=1", got.size()); end
    total++; if ((got.size() > 0 ? got[0] : -999) !== 127) begin bad++; $display("FAIL sat_value got=%0d want=127", got.size() > 0 ? got[0] : -999); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL sat_done got=%0d want=1", done_cnt); end
  endtask

  task automatic test_negative();
    int want;
`ifdef CONV_RELU_EN
    want = 0;
`else
    want = -128;
`endif
    clear_beats();
    add_beat(fill_win(-4, NE), fill_wgt(7, NE), 8'd0);
    do_start(1, 1, 2);
    run_job(1, 1'b1);
    total++; if ((got.size() > 0 ? got[0] : -999) !== want) begin bad++; $display("FAIL neg_sat got=%0d want=%0d", got.size() > 0 ? got[0] : -999, want); end
  endtask

  task automatic test_rounding();
    int want[3];
    want[0] = 3; want[2] = 4;
`ifdef CONV_RELU_EN
    want[1] = 0;
`else
    want[1] = -2;
`endif
    clear_beats();
    add_beat(fill_win(1, 10), fill_wgt(1, NE), 8'd0);
    add_beat(fill_win(-1, 10), fill_wgt(1, NE), 8'd0);
    add_beat(fill_win(1, 10), fill_wgt(1, NE), 8'd1);
    do_start(1, 3, 2);
    run_job(0, 1'b0);
    total++; if (got.size() !== 3) begin bad++; $display("FAIL round_count got=%0d want=3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if ((i < got.size() ? got[i] : -999) !== want[i]) begin
        bad++; $display("FAIL round_%0d got=%0d want=%0d", i, i < got.size() ? got[i] : -999, want[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    clear_beats();
    for (int i = 0; i < 4; i++) add_beat(rand_win(), rand_wgt(), BW'($urandom));
    build_expected(1, 4, 1);
    do_start(1, 4, 1);
    run_job(2, 1'b1);
    total++; if (stall_seen == 0 || stall_bad !== 0) begin bad++; $display("FAIL bp_win_ready stalls=%0d ready_during_stall=%0d want >0/0", stall_seen, stall_bad); end
    total++; if (got.size() !== 4) begin bad++; $display("FAIL bp_count got=%0d want=4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if ((i < got.size() ? got[i] : -999) !== expq[i]) begin
        bad++; $display("FAIL bp_pixel_%0d got=%0d want=%0d", i, i < got.size() ? got[i] : -999, expq[i]);
      end
    end
    total++; if (done_cnt !== 1 || hs_at_done !== 4 || busy_at_done !== 0) begin bad++; $display("FAIL bp_done cnt=%0d hs=%0d busy=%0d want=1/4/0", done_cnt, hs_at_done, busy_at_done); end
  endtask

  task automatic test_zero_out();
    clear_beats();
    do_start(2, 0, 0);
    run_job(1, 1'b1);
    total++; if (got.size() !== 0 || extra_valid !== 0) begin bad++; $display("FAIL zero_no_output got=%0d/%0d want=0/0", got.size(), extra_valid); end
    total++; if (done_cnt !== 1 || done_cycle !== 1) begin bad++; $display("FAIL zero_done cnt=%0d cycle=%0d want=1/1", done_cnt, done_cycle); end
  endtask

  task automatic test_start_busy();
    clear_beats();
    for (int i = 0; i < 6; i++) add_beat(rand_win(), rand_wgt(), BW'($urandom));
    build_expected(2, 3, 1);
    do_start(2, 3, 1);
    noise_start = 1'b1;
    run_job(0, 1'b0);
    noise_start = 1'b0;
    total++; if (got.size() !== 3) begin bad++; $display("FAIL busy_start_count got=%0d want=3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if ((i < got.size() ? got[i] : -999) !== expq[i]) begin
        bad++; $display("FAIL busy_start_pixel_%0d got=%0d want=%0d", i, i < got.size() ? got[i] : -999, expq[i]);
      end
    end
    total++; if (done_cnt !== 1 || busy_after !== 0) begin bad++; $display("FAIL busy_start_done cnt=%0d busy_after=%0d want=1/0", done_cnt, busy_after); end
  endtask

  task automatic test_reset_mid();
    int idx = 0;
    clear_beats();
    for (int i = 0; i < 6; i++) add_beat(rand_win(), rand_wgt(), BW'($urandom));
    do_start(2, 3, 0);
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      win_valid = 1'b1; win_data = bw[idx]; wgt_data = bk[idx]; bias = bb[idx];
      #1; if (win_valid && win_ready) idx++;
      @(negedge clk);
    end
    win_valid = 1'b1; #1;
    total++; if (out_valid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL mid_pre got=%b%b want=11", out_valid, busy); end
    #2 rst = 1'b1; #1;
    total++; if (win_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL mid_reset got=%b%b%0d%b%b want=00000", win_ready, out_valid, out_data, busy, done);
    end
    @(negedge clk); rst = 1'b0; out_ready = 1'b1; @(negedge clk); #1;
    total++; if (win_ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_no_restart got=%b%b want=00", win_ready, busy); end
    win_valid = 1'b0; @(negedge clk);
  endtask

  task automatic test_random();
    int nc, nout, sh, nce;
    for (int j = 0; j < 10; j++) begin
      nc = $urandom_range(0, 3); nout = $urandom_range(1, 5);
      sh = (($urandom % 4) == 0) ? $urandom_range(13, 31) : $urandom_range(0, 12);
      nce = (nc == 0) ? 1 : nc;
      clear_beats();
      for (int i = 0; i < nce * nout; i++) add_beat(rand_win(), rand_wgt(), BW'($urandom));
      build_expected(nc, nout, sh);
      do_start(nc, nout, sh);
      run_job(0, 1'b0);
      total++; if (got.size() !== nout) begin bad++; $display("FAIL rand%0d_count got=%0d want=%0d", j, got.size(), nout); end
      for (int i = 0; i < nout; i++) begin
        total++;
        if ((i < got.size() ? got[i] : -999) !== expq[i]) begin
          bad++; $display("FAIL rand%0d_pixel_%0d got=%0d want=%0d", j, i, i < got.size() ? got[i] : -999, expq[i]);
        end
      end
      total++; if (done_cnt !== 1 || hs_at_done !== nout || stall_bad !== 0) begin
        bad++; $display("FAIL rand%0d_proto done=%0d hs=%0d stall_bad=%0d want=1/%0d/0", j, done_cnt, hs_at_done, stall_bad, nout);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_num_ch = '0; cfg_num_out = '0; cfg_shift = '0;
    win_valid = 1'b0; win_data = '0; wgt_data = '0; bias = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_saturate();
    test_negative();
    test_rounding();
    test_backpressure();
    test_zero_out();
    test_start_busy();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
